// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types: entry layout, type codes, sizing defaults.
// Imported by the ROB and by anything that decodes commit traffic.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEF    = 16;
  localparam int ROB_POS_WID_DEF = 4;

  typedef enum logic [1:0] {
    T_REG = 2'd0,
    T_BR  = 2'd1,
    T_ST  = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
    logic        pred_jump;
    logic        real_jump;
    logic [31:0] jump_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue/commit, two writeback ports,
// operand query with same-cycle bypass, branch mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE    = ROB_SIZE_DEF,
  parameter int ROB_POS_WID = $clog2(ROB_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue,
  input  logic [1:0]             issue_type,
  input  logic [4:0]             issue_rd,
  input  logic [31:0]            issue_pc,
  input  logic                   issue_pred_jump,
  output logic                   rob_full,
  output logic [ROB_POS_WID-1:0] issue_rob_pos,
  input  logic                   alu_wb,
  input  logic [ROB_POS_WID-1:0] alu_wb_pos,
  input  logic [31:0]            alu_wb_val,
  input  logic                   alu_wb_jump,
  input  logic [31:0]            alu_wb_jump_pc,
  input  logic                   lsb_wb,
  input  logic [ROB_POS_WID-1:0] lsb_wb_pos,
  input  logic [31:0]            lsb_wb_val,
  input  logic [ROB_POS_WID-1:0] q1_pos,
  input  logic [ROB_POS_WID-1:0] q2_pos,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [31:0]            q1_val,
  output logic [31:0]            q2_val,
  output logic                   commit,
  output logic [4:0]             commit_rd,
  output logic [31:0]            commit_val,
  output logic [ROB_POS_WID-1:0] commit_rob_pos,
  output logic                   commit_store,
  output logic [ROB_POS_WID-1:0] commit_store_pos,
  output logic                   rollback,
  output logic [31:0]            rollback_pc
);

  localparam int W  = ROB_POS_WID;
  localparam int CW = ROB_POS_WID + 1;

  rob_entry_t     ent [ROB_SIZE];
  logic [W-1:0]   head;
  logic [W-1:0]   tail;
  logic [CW-1:0]  count;
  logic           commit_q;
  logic           store_q;
  logic           rb_q;
  rob_entry_t     h;
  logic           issue_ok;
  logic           can_commit;
  logic           mispred;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] p);
    return (p == W'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pulses are held while frozen and only shown when rdy is high.
  assign commit       = commit_q & rdy;
  assign commit_store = store_q & rdy;
  assign rollback     = rb_q & rdy;

  assign rob_full      = (count == CW'(ROB_SIZE));
  assign issue_rob_pos = tail;

  assign h          = ent[head];
  assign issue_ok   = issue && !rob_full && !rb_q;
  assign can_commit = (count != '0) && h.busy && h.ready;
  assign mispred    = (h.typ == T_BR) &&
                      (h.real_jump != h.pred_jump);

  // ALU port wins when both writebacks hit the queried entry.
  always_comb begin
    q1_ready = ent[q1_pos].ready;
    q1_val   = ent[q1_pos].val;
    q2_ready = ent[q2_pos].ready;
    q2_val   = ent[q2_pos].val;
    if (lsb_wb && lsb_wb_pos == q1_pos) begin
      q1_ready = 1'b1;
      q1_val   = lsb_wb_val;
    end
    if (alu_wb && alu_wb_pos == q1_pos) begin
      q1_ready = 1'b1;
      q1_val   = alu_wb_val;
    end
    if (lsb_wb && lsb_wb_pos == q2_pos) begin
      q2_ready = 1'b1;
      q2_val   = lsb_wb_val;
    end
    if (alu_wb && alu_wb_pos == q2_pos) begin
      q2_ready = 1'b1;
      q2_val   = alu_wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      commit_q         <= 1'b0;
      store_q          <= 1'b0;
      rb_q             <= 1'b0;
      commit_rd        <= '0;
      commit_val       <= '0;
      commit_rob_pos   <= '0;
      commit_store_pos <= '0;
      rollback_pc      <= '0;
    end else if (rdy) begin
      commit_q <= 1'b0;
      store_q  <= 1'b0;
      rb_q     <= 1'b0;
      if (issue_ok) begin
        ent[tail].busy      <= 1'b1;
        ent[tail].ready     <= 1'b0;
        ent[tail].typ       <= rob_type_e'(issue_type);
        ent[tail].rd        <= issue_rd;
        ent[tail].pc        <= issue_pc;
        ent[tail].pred_jump <= issue_pred_jump;
        ent[tail].real_jump <= 1'b0;
        tail                <= nxt(tail);
      end
      if (alu_wb && !rb_q && ent[alu_wb_pos].busy) begin
        ent[alu_wb_pos].ready     <= 1'b1;
        ent[alu_wb_pos].val       <= alu_wb_val;
        ent[alu_wb_pos].real_jump <= alu_wb_jump;
        ent[alu_wb_pos].jump_pc   <= alu_wb_jump_pc;
      end
      if (lsb_wb && !rb_q && ent[lsb_wb_pos].busy) begin
        ent[lsb_wb_pos].ready <= 1'b1;
        ent[lsb_wb_pos].val   <= lsb_wb_val;
      end
      count <= count + CW'(issue_ok) - CW'(can_commit);
      if (can_commit) begin
        ent[head].busy  <= 1'b0;
        ent[head].ready <= 1'b0;
        head            <= nxt(head);
        unique case (1'b1)
          mispred: begin
            rb_q        <= 1'b1;
            rollback_pc <= h.real_jump ? h.jump_pc : h.pc + 32'd4;
            for (int i = 0; i < ROB_SIZE; i++) begin
              ent[i].busy  <= 1'b0;
              ent[i].ready <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
          end
          (h.typ == T_ST): begin
            store_q          <= 1'b1;
            commit_store_pos <= head;
          end
          default: begin
            if (h.typ == T_REG || h.rd != 5'd0) begin
              commit_q       <= 1'b1;
              commit_rd      <= h.rd;
              commit_val     <= h.val;
              commit_rob_pos <= head;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed stimulus queues the
// expected commit/store/rollback pulses, a negedge monitor pops them.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        issue = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0;
  logic        issue_pred_jump = 1'b0;
  logic        rob_full;
  logic [3:0]  issue_rob_pos;
  logic        alu_wb = 1'b0;
  logic [3:0]  alu_wb_pos = '0;
  logic [31:0] alu_wb_val = '0;
  logic        alu_wb_jump = 1'b0;
  logic [31:0] alu_wb_jump_pc = '0;
  logic        lsb_wb = 1'b0;
  logic [3:0]  lsb_wb_pos = '0;
  logic [31:0] lsb_wb_val = '0;
  logic [3:0]  q1_pos = '0;
  logic [3:0]  q2_pos = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;
  logic        commit_store;
  logic [3:0]  commit_store_pos;
  logic        rollback;
  logic [31:0] rollback_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .rob_full(rob_full), .issue_rob_pos(issue_rob_pos),
    .alu_wb(alu_wb), .alu_wb_pos(alu_wb_pos), .alu_wb_val(alu_wb_val),
    .alu_wb_jump(alu_wb_jump), .alu_wb_jump_pc(alu_wb_jump_pc),
    .lsb_wb(lsb_wb), .lsb_wb_pos(lsb_wb_pos), .lsb_wb_val(lsb_wb_val),
    .q1_pos(q1_pos), .q2_pos(q2_pos),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos),
    .commit_store(commit_store), .commit_store_pos(commit_store_pos),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  pos;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_commit(logic [4:0] rd, logic [31:0] v, logic [3:0] p);
    ev_t e;
    e.kind = 0; e.a = 32'(rd); e.b = v; e.pos = p;
    sb.push_back(e);
  endtask

  task automatic exp_store(logic [3:0] p);
    ev_t e;
    e.kind = 1; e.a = '0; e.b = '0; e.pos = p;
    sb.push_back(e);
  endtask

  task automatic exp_rb(logic [31:0] pc);
    ev_t e;
    e.kind = 2; e.a = '0; e.b = pc; e.pos = '0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    logic [31:0] k;
    if (commit || commit_store || rollback) begin
      k = rollback ? 32'd2 : commit_store ? 32'd1 : 32'd0;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", k, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", k, 32'(e.kind));
        case (e.kind)
          0: begin
            chk("commit_rd", 32'(commit_rd), e.a);
            chk("commit_val", commit_val, e.b);
            chk("commit_rob_pos", 32'(commit_rob_pos), 32'(e.pos));
          end
          1: chk("commit_store_pos", 32'(commit_store_pos), 32'(e.pos));
          default: chk("rollback_pc", rollback_pc, e.b);
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(logic [1:0] t, logic [4:0] rd,
                          logic [31:0] pc, logic pj);
    issue = 1'b1; issue_type = t; issue_rd = rd;
    issue_pc = pc; issue_pred_jump = pj;
    tick();
    issue = 1'b0;
  endtask

  task automatic wb_alu(logic [3:0] p, logic [31:0] v,
                        logic j, logic [31:0] jpc);
    alu_wb = 1'b1; alu_wb_pos = p; alu_wb_val = v;
    alu_wb_jump = j; alu_wb_jump_pc = jpc;
    tick();
    alu_wb = 1'b0;
  endtask

  task automatic wb_lsb(logic [3:0] p, logic [31:0] v);
    lsb_wb = 1'b1; lsb_wb_pos = p; lsb_wb_val = v;
    tick();
    lsb_wb = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_rob_full", 32'(rob_full), 0);
    chk("rst_tail", 32'(issue_rob_pos), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_commit_rd", 32'(commit_rd), 0);
    chk("rst_commit_val", commit_val, 0);
    chk("rst_rollback_pc", rollback_pc, 0);

    // in-order commit from out-of-order writeback
    for (int i = 0; i < 3; i++) begin
      chk("ooo_issue_pos", 32'(issue_rob_pos), 32'(i));
      do_issue(2'd0, 5'(5 + i), 32'h1000 + 32'(4 * i), 1'b0);
    end
    exp_commit(5'd5, 32'h10, 4'd0);
    exp_commit(5'd6, 32'h20, 4'd1);
    exp_commit(5'd7, 32'h30, 4'd2);
    wb_alu(4'd2, 32'h30, 1'b0, 32'h0);
    wb_lsb(4'd0, 32'h10);
    wb_alu(4'd1, 32'h20, 1'b0, 32'h0);
    idle(5);

    // dual writeback and query bypass
    chk("dual_issue_pos", 32'(issue_rob_pos), 3);
    do_issue(2'd0, 5'd1, 32'h2000, 1'b0);
    do_issue(2'd0, 5'd2, 32'h2004, 1'b0);
    q1_pos = 4'd3; q2_pos = 4'd4;
    #1;
    chk("q1_ready_before", 32'(q1_ready), 0);
    alu_wb = 1'b1; alu_wb_pos = 4'd3; alu_wb_val = 32'hAAA;
    alu_wb_jump = 1'b0; alu_wb_jump_pc = '0;
    lsb_wb = 1'b1; lsb_wb_pos = 4'd4; lsb_wb_val = 32'hBBB;
    #1;
    chk("q1_ready_byp", 32'(q1_ready), 1);
    chk("q1_val_byp", q1_val, 32'hAAA);
    chk("q2_ready_byp", 32'(q2_ready), 1);
    chk("q2_val_byp", q2_val, 32'hBBB);
    exp_commit(5'd1, 32'hAAA, 4'd3);
    exp_commit(5'd2, 32'hBBB, 4'd4);
    tick();
    alu_wb = 1'b0; lsb_wb = 1'b0;
    chk("q2_ready_stored", 32'(q2_ready), 1);
    chk("q2_val_stored", q2_val, 32'hBBB);
    idle(4);

    // rdy freeze with a ready head
    do_issue(2'd0, 5'd9, 32'h3000, 1'b0);
    wb_alu(4'd5, 32'h99, 1'b0, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frozen_commit", 32'(commit), 0);
    end
    exp_commit(5'd9, 32'h99, 4'd5);
    rdy = 1'b1;
    tick();
    chk("unfreeze_commit", 32'(commit), 1);
    tick();
    chk("single_pulse", 32'(commit), 0);
    idle(2);

    // reset mid-stream discards ready entries
    do_issue(2'd0, 5'd12, 32'h4000, 1'b0);
    do_issue(2'd0, 5'd13, 32'h4004, 1'b0);
    alu_wb = 1'b1; alu_wb_pos = 4'd6; alu_wb_val = 32'h66;
    lsb_wb = 1'b1; lsb_wb_pos = 4'd7; lsb_wb_val = 32'h77;
    tick();
    alu_wb = 1'b0; lsb_wb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_commit", 32'(commit), 0);
    chk("mid_rst_full", 32'(rob_full), 0);
    chk("mid_rst_tail", 32'(issue_rob_pos), 0);
    idle(3);

    // fill, overflow, wrap, commit alongside issue
    for (int i = 0; i < 16; i++) begin
      chk("fill_pos", 32'(issue_rob_pos), 32'(i));
      do_issue(2'd0, 5'(i + 1), 32'h5000 + 32'(4 * i), 1'b0);
    end
    chk("full_flag", 32'(rob_full), 1);
    chk("full_tail_wrap", 32'(issue_rob_pos), 0);
    do_issue(2'd0, 5'd20, 32'h6000, 1'b0);
    chk("full_issue_ignored", 32'(issue_rob_pos), 0);
    chk("full_still", 32'(rob_full), 1);
    exp_commit(5'd1, 32'h500, 4'd0);
    issue = 1'b1; issue_type = 2'd0; issue_rd = 5'd20;
    alu_wb = 1'b1; alu_wb_pos = 4'd0; alu_wb_val = 32'h500;
    tick();
    alu_wb = 1'b0;
    tick();
    issue = 1'b0;
    chk("freed_not_full", 32'(rob_full), 0);
    chk("blocked_tail", 32'(issue_rob_pos), 0);
    issue = 1'b1; issue_rd = 5'd21;
    alu_wb = 1'b1; alu_wb_pos = 4'd1; alu_wb_val = 32'h501;
    tick();
    issue = 1'b0; alu_wb = 1'b0;
    chk("refull", 32'(rob_full), 1);
    chk("refull_tail", 32'(issue_rob_pos), 1);
    exp_commit(5'd2, 32'h501, 4'd1);
    wb_alu(4'd2, 32'h502, 1'b0, 32'h0);
    chk("after_c1_full", 32'(rob_full), 0);
    exp_commit(5'd3, 32'h502, 4'd2);
    do_issue(2'd0, 5'd22, 32'h6008, 1'b0);
    chk("iss_com_full", 32'(rob_full), 0);
    chk("iss_com_tail", 32'(issue_rob_pos), 2);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(1);

    // branch mispredict flushes younger entries
    do_issue(2'd1, 5'd0, 32'h100, 1'b1);
    do_issue(2'd0, 5'd10, 32'h104, 1'b0);
    do_issue(2'd0, 5'd11, 32'h108, 1'b0);
    wb_lsb(4'd1, 32'h11);
    wb_lsb(4'd2, 32'h12);
    exp_rb(32'h104);
    wb_alu(4'd0, 32'h0, 1'b0, 32'h200);
    tick();
    chk("rb_pulse", 32'(rollback), 1);
    chk("rb_pc", rollback_pc, 32'h104);
    issue = 1'b1; issue_type = 2'd0; issue_rd = 5'd30;
    tick();
    issue = 1'b0;
    chk("rb_issue_dropped", 32'(issue_rob_pos), 0);
    chk("rb_done", 32'(rollback), 0);
    chk("rb_not_full", 32'(rob_full), 0);
    idle(3);

    // store commit, linked branch, silent branch
    do_issue(2'd2, 5'd0, 32'h300, 1'b0);
    do_issue(2'd1, 5'd1, 32'h40, 1'b0);
    do_issue(2'd1, 5'd0, 32'h50, 1'b1);
    exp_store(4'd0);
    exp_commit(5'd1, 32'h44, 4'd1);
    wb_lsb(4'd0, 32'h0);
    wb_alu(4'd1, 32'h44, 1'b0, 32'h999);
    wb_alu(4'd2, 32'h0, 1'b1, 32'h80);
    idle(6);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
